// File: rtl/mmio_uart_ctrl.sv
// MMIO block on the MWB data path: UART TX holding register, RX byte FIFO and
// cycle/instruction counters, with 1-cycle registered read data like dmem.
module mmio_uart_ctrl #(
    parameter int         RX_FIFO_DEPTH = 8,
    parameter logic [3:0] MMIO_NIBBLE   = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_re,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        inst_retire,
    output logic        mmio_hit,
    output logic [31:0] resp_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int              PTR_W      = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(RX_FIFO_DEPTH);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    logic [7:0]       offset;
    logic             hit;
    logic             load_hit;
    logic             store_hit;

    logic [7:0]       rx_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] rx_rd_ptr;
    logic [PTR_W-1:0] rx_wr_ptr;
    logic [PTR_W:0]   rx_count;
    logic             rx_nonempty;
    logic             rx_push;
    logic             rx_pop;

    logic             tx_free;
    logic             tx_handshake;
    logic             tx_slot_open;
    logic             tx_write;
    logic             tx_drop;

    logic             counters_clear;
    logic [31:0]      cycle_cnt;
    logic [31:0]      instr_cnt;
    logic [31:0]      rd_mux;

    logic             unused_bits;

    assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

    assign offset    = req_addr[7:0];
    assign hit       = (req_re | (|req_we)) & (req_addr[31:28] == MMIO_NIBBLE);
    assign load_hit  = hit & req_re;
    assign store_hit = hit & (|req_we);

    assign rx_nonempty   = (rx_count != '0);
    assign uart_rx_ready = (rx_count != FULL_COUNT);
    assign rx_push       = uart_rx_valid & uart_rx_ready;
    assign rx_pop        = load_hit & (offset == OFF_RXDATA) & rx_nonempty;

    // A handshake in the same cycle frees the slot, so a concurrent write is taken.
    assign tx_free      = !uart_tx_valid;
    assign tx_handshake = uart_tx_valid & uart_tx_ready;
    assign tx_slot_open = tx_free | tx_handshake;
    assign tx_write     = store_hit & (offset == OFF_TXDATA) & req_we[0];

    assign counters_clear = store_hit & (offset == OFF_CLEAR);

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_STATUS: rd_mux = {29'b0, tx_drop, rx_nonempty, tx_free};
            OFF_RXDATA: rd_mux = rx_nonempty ? {24'b0, rx_mem[rx_rd_ptr]} : 32'b0;
            OFF_CYCLE:  rd_mux = cycle_cnt;
            OFF_INSTR:  rd_mux = instr_cnt;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_hit   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mmio_hit   <= hit;
            resp_rdata <= load_hit ? rd_mux : 32'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
            tx_drop       <= 1'b0;
        end else begin
            if (tx_write && tx_slot_open) begin
                uart_tx_valid <= 1'b1;
                uart_tx_data  <= req_wdata[7:0];
            end else if (tx_handshake) begin
                uart_tx_valid <= 1'b0;
            end

            // Sticky until a status read has reported it.
            if (tx_write && !tx_slot_open) begin
                tx_drop <= 1'b1;
            end else if (load_hit && (offset == OFF_STATUS)) begin
                tx_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (PTR_W+1)'(1);
                2'b01:   rx_count <= rx_count - (PTR_W+1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (counters_clear) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end

endmodule
